// File: rtl/seq_shifter_if.sv
// Request/result bundle for seq_shifter: the requester drives start and operands,
// the shifter returns result, cout and its ready/busy/done status.
interface seq_shifter_if #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   operand;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   result;
   logic               cout;
   logic               ready;
   logic               busy;
   logic               done;

   modport master (
      output start, op, operand, shamt,
      input  result, cout, ready, busy, done
   );

   modport slave (
      input  start, op, operand, shamt,
      output result, cout, ready, busy, done
   );
endinterface

// File: rtl/seq_shifter.sv
// Bit-serial shifter: one position per cycle, done pulses shamt+1 cycles after the accepting edge.
// Starts are taken only while ready (IDLE/DONE); ROL for op=11 exists only with SEQ_SHIFTER_ROTATE_EN.
module seq_shifter #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input logic          clk,
   input logic          rst,
   seq_shifter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SHAMT_W-1:0] cnt;
   logic [WIDTH-1:0]   result_q;
   logic               cout_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   shift_val;
   logic               shift_cout;
   logic               accept;
   logic               ready_int;

   // One-position step for the latched mode; op=11 falls back to SLL when rotate is absent.
   always_comb begin
      shift_val  = {result_q[WIDTH-2:0], 1'b0};
      shift_cout = result_q[WIDTH-1];
      case (op_q)
         2'b01: begin
            shift_val  = {1'b0, result_q[WIDTH-1:1]};
            shift_cout = result_q[0];
         end
         2'b10: begin
            shift_val  = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            shift_cout = result_q[0];
         end
`ifdef SEQ_SHIFTER_ROTATE_EN
         2'b11: begin
            shift_val  = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
            shift_cout = result_q[WIDTH-1];
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ready_int = 1'b0;
      case (state)
         IDLE: ready_int = 1'b1;
         SHIFT: begin
            if (cnt == SHAMT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            ready_int = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      accept = bus.start && ready_int;
      if (accept) state_nxt = (bus.shamt == '0) ? DONE : SHIFT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         op_q     <= 2'b00;
      end else if (accept) begin
         cnt      <= bus.shamt;
         result_q <= bus.operand;
         cout_q   <= 1'b0;
         op_q     <= bus.op;
      end else if (state == SHIFT) begin
         cnt      <= cnt - SHAMT_W'(1);
         result_q <= shift_val;
         cout_q   <= shift_cout;
      end
   end

   assign bus.result = result_q;
   assign bus.cout   = cout_q;
   assign bus.ready  = ready_int;
   assign bus.busy   = (state == SHIFT);
   assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=16, SHAMT_W=4); rotate expectations follow SEQ_SHIFTER_ROTATE_EN.
module tb_seq_shifter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   seq_shifter_if #(.WIDTH(16), .SHAMT_W(4)) bus ();

   seq_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Caller sits just after a falling edge; the request is taken on the next rising edge.
   task automatic kick(input logic [1:0] o, input logic [15:0] d, input logic [3:0] s);
      bus.start   = 1'b1;
      bus.op      = o;
      bus.operand = d;
      bus.shamt   = s;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic test_reset;
      bus.start = 1'b0; bus.op = 2'b00; bus.operand = 16'h0; bus.shamt = 4'd0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vec_cnt++; if (bus.ready !== 1'b1) begin err_cnt++; $display("FAIL rst_hold_ready: got %b expected 1", bus.ready); end
      vec_cnt++; if (bus.result !== 16'h0000) begin err_cnt++; $display("FAIL rst_hold_result: got %h expected 0000", bus.result); end
      rst = 1'b0;
      #1;
      vec_cnt++; if (bus.result !== 16'h0000) begin err_cnt++; $display("FAIL rel_result: got %h expected 0000", bus.result); end
      vec_cnt++; if (bus.ready !== 1'b1) begin err_cnt++; $display("FAIL rel_ready: got %b expected 1", bus.ready); end
      vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL rel_busy: got %b expected 0", bus.busy); end
      vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL rel_done: got %b expected 0", bus.done); end
   endtask

   task automatic test_sll;
      kick(2'b00, 16'h8001, 4'd1);
      @(negedge clk);
      vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL sll_busy_c1: got %b expected 1", bus.busy); end
      vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL sll_done_c1: got %b expected 0", bus.done); end
      @(negedge clk);
      vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL sll_done_c2: got %b expected 1", bus.done); end
      vec_cnt++; if (bus.result !== 16'h0002) begin err_cnt++; $display("FAIL sll_result: got %h expected 0002", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b1) begin err_cnt++; $display("FAIL sll_cout: got %b expected 1", bus.cout); end
      @(negedge clk);
      vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL sll_done_c3: got %b expected 0", bus.done); end
      vec_cnt++; if (bus.result !== 16'h0002) begin err_cnt++; $display("FAIL sll_hold: got %h expected 0002", bus.result); end
   endtask

   task automatic test_sra;
      @(negedge clk);
      kick(2'b10, 16'h8000, 4'd15);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         vec_cnt++;
         if (bus.done !== (k == 16)) begin
            err_cnt++; $display("FAIL sra_done_c%0d: got %b expected %b", k, bus.done, (k == 16));
         end
      end
      vec_cnt++; if (bus.result !== 16'hFFFF) begin err_cnt++; $display("FAIL sra_result: got %h expected ffff", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b0) begin err_cnt++; $display("FAIL sra_cout: got %b expected 0", bus.cout); end
   endtask

   task automatic test_srl_max;
      @(negedge clk);
      kick(2'b01, 16'hFFFF, 4'd15);
      repeat (16) @(negedge clk);
      vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL srl15_done: got %b expected 1", bus.done); end
      vec_cnt++; if (bus.result !== 16'h0001) begin err_cnt++; $display("FAIL srl15_result: got %h expected 0001", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b1) begin err_cnt++; $display("FAIL srl15_cout: got %b expected 1", bus.cout); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      kick(2'b00, 16'h1234, 4'd0);
      @(negedge clk);
      vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL zero_done: got %b expected 1", bus.done); end
      vec_cnt++; if (bus.result !== 16'h1234) begin err_cnt++; $display("FAIL zero_result: got %h expected 1234", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b0) begin err_cnt++; $display("FAIL zero_cout: got %b expected 0", bus.cout); end
      vec_cnt++; if (bus.ready !== 1'b1) begin err_cnt++; $display("FAIL zero_ready: got %b expected 1", bus.ready); end
      kick(2'b01, 16'h1234, 4'd4);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         vec_cnt++;
         if (bus.done !== (k == 5)) begin
            err_cnt++; $display("FAIL b2b_done_c%0d: got %b expected %b", k, bus.done, (k == 5));
         end
      end
      vec_cnt++; if (bus.result !== 16'h0123) begin err_cnt++; $display("FAIL b2b_result: got %h expected 0123", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b0) begin err_cnt++; $display("FAIL b2b_cout: got %b expected 0", bus.cout); end
      @(negedge clk);
      vec_cnt++; if (bus.result !== 16'h0123) begin err_cnt++; $display("FAIL b2b_hold: got %h expected 0123", bus.result); end
   endtask

   task automatic test_ignored_start;
      @(negedge clk);
      kick(2'b00, 16'h0001, 4'd8);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         vec_cnt++;
         if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            err_cnt++; $display("FAIL ign_busy_c%0d: got busy=%b ready=%b expected busy=1 ready=0", k, bus.busy, bus.ready);
         end
         // Hammer the inputs with a conflicting request for a few cycles.
         bus.start   = (k >= 2 && k <= 4);
         bus.op      = 2'b10;
         bus.operand = 16'hFFFF;
         bus.shamt   = 4'd1;
      end
      bus.start = 1'b0;
      @(negedge clk);
      vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL ign_done: got %b expected 1", bus.done); end
      vec_cnt++; if (bus.result !== 16'h0100) begin err_cnt++; $display("FAIL ign_result: got %h expected 0100", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b0) begin err_cnt++; $display("FAIL ign_cout: got %b expected 0", bus.cout); end
   endtask

   task automatic test_reset_mid_shift;
      @(negedge clk);
      kick(2'b01, 16'hF0F3, 4'd10);
      repeat (3) @(negedge clk);
      vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL mid_busy: got %b expected 1", bus.busy); end
      rst = 1'b1;
      #1;
      vec_cnt++; if (bus.result !== 16'h0000) begin err_cnt++; $display("FAIL mid_rst_result: got %h expected 0000", bus.result); end
      vec_cnt++; if (bus.cout !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_cout: got %b expected 0", bus.cout); end
      vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
      vec_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_done: got %b expected 0", bus.done); end
      vec_cnt++; if (bus.ready !== 1'b1) begin err_cnt++; $display("FAIL mid_rst_ready: got %b expected 1", bus.ready); end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      vec_cnt++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 16'h0000) begin
         err_cnt++; $display("FAIL post_rst_idle: got done=%b busy=%b result=%h expected 0 0 0000", bus.done, bus.busy, bus.result);
      end
   endtask

   task automatic test_rotate;
      logic [15:0] exp_res;
`ifdef SEQ_SHIFTER_ROTATE_EN
      exp_res = 16'h0018;
`else
      exp_res = 16'h0010;
`endif
      kick(2'b11, 16'h8001, 4'd4);
      repeat (5) @(negedge clk);
      vec_cnt++; if (bus.done !== 1'b1) begin err_cnt++; $display("FAIL rol_done: got %b expected 1", bus.done); end
      vec_cnt++; if (bus.result !== exp_res) begin err_cnt++; $display("FAIL rol_result: got %h expected %h", bus.result, exp_res); end
      vec_cnt++; if (bus.cout !== 1'b0) begin err_cnt++; $display("FAIL rol_cout: got %b expected 0", bus.cout); end
   endtask

   initial begin
      test_reset();
      test_sll();
      test_sra();
      test_srl_max();
      test_back_to_back();
      test_ignored_start();
      test_reset_mid_shift();
      test_rotate();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (>= 2).
REQ-002 SHALL have parameter SHAMT_W, default 4, shift-amount width in bits; maximum shift is 2^SHAMT_W-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request pulse; operands sampled when start=1 and ready=1.
REQ-006 SHALL have port op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
REQ-007 SHALL have port operand  input  WIDTH  value to shift.
REQ-008 SHALL have port shamt  input  SHAMT_W  number of bit positions to shift.
REQ-009 SHALL have port result  output  WIDTH  shifted value, held until the next accepted start.
REQ-010 SHALL have port cout  output  1  last bit shifted out (0 if shamt=0).
REQ-011 SHALL have port ready  output  1  high in IDLE and DONE; start accepted only when high.
REQ-012 SHALL have port busy  output  1  high in SHIFT.
REQ-013 SHALL have port done  output  1  one-cycle pulse, high in DONE.

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE; exactly one active at any time.
REQ-015 On an accepted start, SHALL load operand into result, clear cout, latch op, and load the shamt counter.
REQ-016 On an accepted start with shamt=0, SHALL go to DONE; with shamt>0, SHALL go to SHIFT.
REQ-017 In SHIFT, SHALL shift result one position per cycle, update cout, and decrement the counter.
REQ-018 SHALL leave SHIFT for DONE on the edge that performs the final shift (counter reaching 0).
REQ-019 Latency: done SHALL be high in cycle shamt+1, counting the cycle after the accepting edge as cycle 1.
REQ-020 SLL SHALL shift in 0 at bit 0; cout SHALL equal the old bit WIDTH-1.
REQ-021 SRL SHALL shift in 0 at bit WIDTH-1; cout SHALL equal the old bit 0.
REQ-022 SRA SHALL replicate bit WIDTH-1; cout SHALL equal the old bit 0.
REQ-023 shamt >= WIDTH SHALL be legal: SLL/SRL give 0, SRA gives all sign bits, ROL wraps modulo WIDTH.
REQ-024 DONE SHALL last one cycle, then return to IDLE unless a start is accepted in DONE.
REQ-025 A start accepted in DONE SHALL behave exactly as a start accepted in IDLE, giving back-to-back operation.
REQ-026 A start while busy=1 SHALL be ignored, and operand, op and shamt changes SHALL have no effect.
REQ-027 result and cout SHALL remain stable in IDLE and DONE.

Reset
REQ-028 Asserting rst, including mid-SHIFT, SHALL immediately force state IDLE and clear the counter.
REQ-029 Asserting rst SHALL immediately set result=0, cout=0, busy=0, done=0 and ready=1.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro SEQ_SHIFTER_ROTATE_EN SHALL control rotate support.
REQ-032 With SEQ_SHIFTER_ROTATE_EN defined, op=11 SHALL perform ROL: bit WIDTH-1 enters bit 0, and cout equals that bit.
REQ-033 Without SEQ_SHIFTER_ROTATE_EN, op=11 SHALL behave identically to SLL and no rotate logic SHALL be present.

Verification
REQ-034 Reset-release scenario: release reset with WIDTH=16 -> result=0x0000, ready=1, busy=0, done=0.
REQ-035 SLL scenario: start, op=00, operand=0x8001, shamt=1 -> busy in cycle 1; in cycle 2, done=1, result=0x0002, cout=1.
REQ-036 SRA scenario: start, op=10, operand=0x8000, shamt=15 -> done in cycle 16 only; result=0xFFFF, cout=0.
REQ-037 Zero-shift and back-to-back scenario: start shamt=0, operand=0x1234 -> done in cycle 1, result=0x1234, cout=0.
REQ-038 Back-to-back follow-on: start again in that DONE cycle with op=01, shamt=4 -> done 5 cycles later, result=0x0123, cout=0.
REQ-039 Ignored-start and reset scenario: start pulses during SHIFT -> ignored.
REQ-040 Reset follow-on: rst mid-SHIFT -> outputs cleared within the same cycle.
REQ-041 Rotate scenario, with SEQ_SHIFTER_ROTATE_EN defined: op=11, operand=0x8001, shamt=4 -> result=0x0018, cout=0.
REQ-042 Rotate scenario, without SEQ_SHIFTER_ROTATE_EN: op=11, operand=0x8001, shamt=4 -> result=0x0010, cout=0.
